// File: rtl/dc_slice_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : dc_slice_scheduler_if
// Description : Requester, encoder and codeword-stream signals of the DC
//               slice scheduler. master = scheduler side, slave = environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface dc_slice_scheduler_if;
    logic               slice_start;
    logic        [5:0]  slice_blocks;
    logic               slice_busy;
    logic        [2:0]  comp_valid;
    logic        [2:0]  comp_ready;
    logic signed [19:0] y_coeff;
    logic signed [19:0] cb_coeff;
    logic signed [19:0] cr_coeff;
    logic               enc_valid;
    logic               enc_first;
    logic signed [19:0] enc_coeff;
    logic        [23:0] enc_code;
    logic        [4:0]  enc_len;
    logic               cw_valid;
    logic               cw_ready;
    logic        [23:0] cw_code;
    logic        [4:0]  cw_len;
    logic        [1:0]  cw_comp;
    logic               cw_last;
    logic               slice_done;
    logic        [15:0] bits_y;
    logic        [15:0] bits_cb;
    logic        [15:0] bits_cr;

    modport master (
        input  slice_start, slice_blocks, comp_valid, y_coeff, cb_coeff, cr_coeff,
               enc_code, enc_len, cw_ready,
        output slice_busy, comp_ready, enc_valid, enc_first, enc_coeff,
               cw_valid, cw_code, cw_len, cw_comp, cw_last, slice_done,
               bits_y, bits_cb, bits_cr
    );

    modport slave (
        output slice_start, slice_blocks, comp_valid, y_coeff, cb_coeff, cr_coeff,
               enc_code, enc_len, cw_ready,
        input  slice_busy, comp_ready, enc_valid, enc_first, enc_coeff,
               cw_valid, cw_code, cw_len, cw_comp, cw_last, slice_done,
               bits_y, bits_cb, bits_cr
    );
endinterface
`default_nettype wire

// File: rtl/dc_slice_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dc_slice_scheduler
// Description : Issues Y, Cb, Cr DC coefficients of a slice to the DC entropy
//               encoder under FIFO credit and queues returned codewords.
// Revision    : 1.0 - initial release
// ============================================================================
module dc_slice_scheduler #(
    parameter int ENC_LAT    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    dc_slice_scheduler_if.master bus
);
    localparam int            AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            CW      = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [CW-1:0] c_DEPTH = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] c_PMAX  = AW'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_Y  = 3'd1,
        ISSUE_CB = 3'd2,
        ISSUE_CR = 3'd3,
        DRAIN    = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [5:0]         r_blk_total, r_blk_cnt;
    logic               r_busy, r_done;
    logic               w_start, w_issue, w_done_nxt, w_blk_last, w_credit_ok;
    logic [1:0]         w_comp;
    logic signed [19:0] w_coeff;
    logic [CW-1:0]      w_inflight, w_count_nxt, r_count;
    logic [ENC_LAT-1:0] r_tag_vld, r_tag_last;
    logic [1:0]         r_tag_comp [ENC_LAT];
    logic               w_push, w_pop, r_cw_valid;
    logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [23:0]        r_mem_code [FIFO_DEPTH];
    logic [4:0]         r_mem_len  [FIFO_DEPTH];
    logic [1:0]         r_mem_comp [FIFO_DEPTH];
    logic               r_mem_last [FIFO_DEPTH];
    logic [15:0]        r_bits [3];
    logic [15:0]        w_bits_cur, w_bits_sat;
    logic [16:0]        w_bits_sum;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < ENC_LAT; i++) w_inflight = w_inflight + CW'(r_tag_vld[i]);
    end

    assign w_credit_ok = (r_count + w_inflight) < c_DEPTH;
    assign w_blk_last  = (r_blk_cnt == r_blk_total - 6'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_issue     = 1'b0;
        w_done_nxt  = 1'b0;
        w_comp      = 2'd0;
        w_coeff     = '0;
        case (r_state)
            IDLE: begin
                if (bus.slice_start && bus.slice_blocks != 6'd0) begin
                    w_start     = 1'b1;
                    w_state_nxt = ISSUE_Y;
                end
            end
            ISSUE_Y: begin
                w_comp  = 2'd0;
                w_coeff = bus.y_coeff;
                w_issue = bus.comp_valid[0] && w_credit_ok;
                if (w_issue && w_blk_last) w_state_nxt = ISSUE_CB;
            end
            ISSUE_CB: begin
                w_comp  = 2'd1;
                w_coeff = bus.cb_coeff;
                w_issue = bus.comp_valid[1] && w_credit_ok;
                if (w_issue && w_blk_last) w_state_nxt = ISSUE_CR;
            end
            ISSUE_CR: begin
                w_comp  = 2'd2;
                w_coeff = bus.cr_coeff;
                w_issue = bus.comp_valid[2] && w_credit_ok;
                if (w_issue && w_blk_last) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_inflight == '0 && r_count == '0) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Issue strobes are combinational so a coefficient reaches the encoder in the pop cycle.
    assign bus.comp_ready = w_issue ? (3'b001 << w_comp) : 3'b000;
    assign bus.enc_valid  = w_issue;
    assign bus.enc_first  = w_issue && (r_blk_cnt == 6'd0);
    assign bus.enc_coeff  = w_issue ? w_coeff : 20'sd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blk_total <= '0;
            r_blk_cnt   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (w_start) begin
                r_blk_total <= bus.slice_blocks;
                r_blk_cnt   <= '0;
                r_busy      <= 1'b1;
            end else if (w_done_nxt) begin
                r_busy <= 1'b0;
            end
            if (w_issue) r_blk_cnt <= w_blk_last ? 6'd0 : r_blk_cnt + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag_vld  <= '0;
            r_tag_last <= '0;
            for (int i = 0; i < ENC_LAT; i++) r_tag_comp[i] <= '0;
        end else begin
            r_tag_vld[0]  <= w_issue;
            r_tag_last[0] <= w_issue && w_blk_last;
            r_tag_comp[0] <= w_comp;
            for (int i = 1; i < ENC_LAT; i++) begin
                r_tag_vld[i]  <= r_tag_vld[i-1];
                r_tag_last[i] <= r_tag_last[i-1];
                r_tag_comp[i] <= r_tag_comp[i-1];
            end
        end
    end

    assign w_push      = r_tag_vld[ENC_LAT-1];
    assign w_pop       = r_cw_valid && bus.cw_ready;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_cw_valid <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_code[i] <= '0;
                r_mem_len[i]  <= '0;
                r_mem_comp[i] <= '0;
                r_mem_last[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_mem_code[r_wr_ptr] <= bus.enc_code;
                r_mem_len[r_wr_ptr]  <= bus.enc_len;
                r_mem_comp[r_wr_ptr] <= r_tag_comp[ENC_LAT-1];
                r_mem_last[r_wr_ptr] <= r_tag_last[ENC_LAT-1];
                r_wr_ptr             <= (r_wr_ptr == c_PMAX) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= (r_rd_ptr == c_PMAX) ? '0 : r_rd_ptr + AW'(1);
            r_count    <= w_count_nxt;
            r_cw_valid <= (w_count_nxt != '0);
        end
    end

    always @(posedge clk) begin
        if (!reset) assert (!(w_push && !w_pop && r_count == c_DEPTH));
    end

    always_comb begin
        w_bits_cur = r_bits[2];
        case (r_tag_comp[ENC_LAT-1])
            2'd0:    w_bits_cur = r_bits[0];
            2'd1:    w_bits_cur = r_bits[1];
            default: w_bits_cur = r_bits[2];
        endcase
        w_bits_sum = {1'b0, w_bits_cur} + 17'(bus.enc_len);
        w_bits_sat = w_bits_sum[16] ? 16'hFFFF : w_bits_sum[15:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 3; c++) r_bits[c] <= '0;
        end else if (w_start) begin
            for (int c = 0; c < 3; c++) r_bits[c] <= '0;
        end else if (w_push) begin
            for (int c = 0; c < 3; c++)
                if (r_tag_comp[ENC_LAT-1] == 2'(c)) r_bits[c] <= w_bits_sat;
        end
    end

    assign bus.slice_busy = r_busy;
    assign bus.slice_done = r_done;
    assign bus.cw_valid   = r_cw_valid;
    assign bus.cw_code    = r_mem_code[r_rd_ptr];
    assign bus.cw_len     = r_mem_len[r_rd_ptr];
    assign bus.cw_comp    = r_mem_comp[r_rd_ptr];
    assign bus.cw_last    = r_mem_last[r_rd_ptr];
    assign bus.bits_y     = r_bits[0];
    assign bus.bits_cb    = r_bits[1];
    assign bus.bits_cr    = r_bits[2];
endmodule
`default_nettype wire

// File: tb/tb_dc_slice_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dc_slice_scheduler
// Description : Self-checking bench: encoder model plus codeword scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dc_slice_scheduler;
    localparam int ENC_LAT    = 4;
    localparam int FIFO_DEPTH = 8;

    typedef struct packed {
        logic [23:0] code;
        logic [4:0]  len;
        logic [1:0]  comp;
        logic        last;
    } cw_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   n_cw = 0;
    int   len_fixed = 0;
    int   idx [3] = '{0, 0, 0};
    int   exp_bits [3] = '{0, 0, 0};
    cw_t  exp_q [$];
    logic [23:0] ring_code [64];
    logic [4:0]  ring_len  [64];

    dc_slice_scheduler_if bif ();

    dc_slice_scheduler #(.ENC_LAT(ENC_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    function automatic logic signed [19:0] coeff_of(input int c, input int b);
        int v;
        v = c * 1000 + b * 7 + 1;
        return (b % 2 == 1) ? 20'(-v) : 20'(v);
    endfunction

    function automatic logic [23:0] code_of(input logic [19:0] co);
        return {4'h5, co};
    endfunction

    function automatic logic [4:0] len_of(input logic [19:0] co);
        return (len_fixed != 0) ? 5'(len_fixed) : ({1'b0, co[3:0]} + 5'd1);
    endfunction

    // Encoder model answers ENC_LAT cycles after issue; coefficients advance on each pop.
    initial begin
        for (int i = 0; i < 64; i++) begin ring_code[i] = '0; ring_len[i] = '0; end
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            bif.enc_code = ring_code[cyc % 64];
            bif.enc_len  = ring_len[cyc % 64];
            ring_code[cyc % 64] = '0;
            ring_len[cyc % 64]  = '0;
            bif.y_coeff  = coeff_of(0, idx[0]);
            bif.cb_coeff = coeff_of(1, idx[1]);
            bif.cr_coeff = coeff_of(2, idx[2]);
        end
    end

    always @(negedge clk) begin
        cw_t got, exp;
        if (!reset) begin
            if (bif.enc_valid) begin
                ring_code[(cyc + ENC_LAT) % 64] = code_of(bif.enc_coeff);
                ring_len[(cyc + ENC_LAT) % 64]  = len_of(bif.enc_coeff);
            end
            for (int c = 0; c < 3; c++) if (bif.comp_ready[c]) idx[c] = idx[c] + 1;
            if (bif.cw_valid && bif.cw_ready) begin
                got = {bif.cw_code, bif.cw_len, bif.cw_comp, bif.cw_last};
                n_cw = n_cw + 1;
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    failures = failures + 1;
                    $display("FAIL cw_unexpected: got %h required none", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        failures = failures + 1;
                        $display("FAIL cw_stream: got %h required %h", got, exp);
                    end
                end
            end
        end
    end

    task automatic start_slice(input int n);
        logic [4:0] l;
        @(posedge clk); #1;
        idx = '{0, 0, 0};
        n_cw = 0;
        exp_bits = '{0, 0, 0};
        for (int c = 0; c < 3; c++) begin
            for (int b = 0; b < n; b++) begin
                l = len_of(coeff_of(c, b));
                exp_q.push_back({code_of(coeff_of(c, b)), l, 2'(c), (b == n - 1)});
                exp_bits[c] = (exp_bits[c] + int'(l) > 65535) ? 65535 : exp_bits[c] + int'(l);
            end
        end
        bif.slice_start  = 1'b1;
        bif.slice_blocks = 6'(n);
        t0 = cyc;
        @(posedge clk); #1;
        bif.slice_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bif.slice_done) begin at = cyc - t0; break; end
        end
        checks = checks + 1;
        if (at < 0) begin
            failures = failures + 1;
            $display("FAIL done_timeout: no slice_done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset;
        logic [107:0] outs;
        repeat (3) @(negedge clk);
        outs = {bif.slice_busy, bif.comp_ready, bif.enc_valid, bif.enc_first, bif.enc_coeff,
                bif.cw_valid, bif.cw_code, bif.cw_len, bif.cw_comp, bif.cw_last,
                bif.slice_done, bif.bits_y, bif.bits_cb, bif.bits_cr};
        checks = checks + 1;
        if (outs !== '0) begin
            failures = failures + 1;
            $display("FAIL reset_outputs: got %h required 0", outs);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic;
        logic [15:0] ev, ef, cwv, dn, bz;
        int k;
        ev = '0; ef = '0; cwv = '0; dn = '0; bz = '0;
        len_fixed = 6;
        bif.comp_valid = 3'b111;
        bif.cw_ready   = 1'b1;
        start_slice(1);
        repeat (14) begin
            @(negedge clk);
            k = cyc - t0;
            if (k >= 0 && k < 16) begin
                ev[k] = bif.enc_valid; ef[k] = bif.enc_first; cwv[k] = bif.cw_valid;
                dn[k] = bif.slice_done; bz[k] = bif.slice_busy;
            end
        end
        checks = checks + 5;
        if (ev !== 16'h000E) begin failures++; $display("FAIL basic_enc_valid: got %h required 000e", ev); end
        if (ef !== 16'h000E) begin failures++; $display("FAIL basic_enc_first: got %h required 000e", ef); end
        if (cwv !== 16'h01C0) begin failures++; $display("FAIL basic_cw_valid: got %h required 01c0", cwv); end
        if (dn !== 16'h0400) begin failures++; $display("FAIL basic_done: got %h required 0400", dn); end
        if (bz !== 16'h03FE) begin failures++; $display("FAIL basic_busy: got %h required 03fe", bz); end
        checks = checks + 2;
        if ({bif.bits_y, bif.bits_cb, bif.bits_cr} !== {16'd6, 16'd6, 16'd6}) begin
            failures++;
            $display("FAIL basic_bits: got %0d/%0d/%0d required 6/6/6", bif.bits_y, bif.bits_cb, bif.bits_cr);
        end
        if (exp_q.size() != 0 || n_cw != 3) begin
            failures++;
            $display("FAIL basic_count: got %0d codewords (%0d left) required 3", n_cw, exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        int n_iss, at;
        n_iss = 0;
        len_fixed = 0;
        bif.cw_ready = 1'b0;
        bif.comp_valid = 3'b111;
        start_slice(16);
        repeat (30) begin
            @(negedge clk);
            if (bif.enc_valid) n_iss++;
        end
        checks = checks + 2;
        if (n_iss != 8) begin failures++; $display("FAIL bp_issues: got %0d required 8", n_iss); end
        if (bif.cw_valid !== 1'b1) begin failures++; $display("FAIL bp_cw_valid: got %b required 1", bif.cw_valid); end
        @(posedge clk); #1;
        bif.cw_ready = 1'b1;
        wait_done(400, at);
        checks = checks + 2;
        if (n_cw != 48 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_count: got %0d codewords (%0d left) required 48", n_cw, exp_q.size());
        end
        if ({bif.bits_y, bif.bits_cb, bif.bits_cr} !== {16'(exp_bits[0]), 16'(exp_bits[1]), 16'(exp_bits[2])}) begin
            failures++;
            $display("FAIL bp_bits: got %0d/%0d/%0d required %0d/%0d/%0d", bif.bits_y, bif.bits_cb,
                     bif.bits_cr, exp_bits[0], exp_bits[1], exp_bits[2]);
        end
    endtask

    task automatic test_comp_stall;
        int ny, bad, at;
        logic seen;
        ny = 0; bad = 0; seen = 1'b0;
        len_fixed = 0;
        bif.cw_ready = 1'b1;
        bif.comp_valid = 3'b101;
        start_slice(4);
        for (int i = 0; i < 20 && ny < 4; i++) begin
            @(negedge clk);
            if (bif.comp_ready[0]) ny++;
            if (bif.comp_ready[2]) bad++;
        end
        repeat (10) begin
            @(negedge clk);
            if (bif.enc_valid) bad++;
        end
        checks = checks + 1;
        if (ny != 4 || bad != 0) begin
            failures++;
            $display("FAIL stall_order: got %0d Y issues and %0d stray issues required 4 and 0", ny, bad);
        end
        @(posedge clk); #1;
        bif.comp_valid = 3'b111;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (bif.enc_valid) begin
                seen = 1'b1;
                checks = checks + 1;
                if ({bif.comp_ready, bif.enc_first} !== 4'b0101) begin
                    failures++;
                    $display("FAIL stall_resume: got ready=%b first=%b required 010/1", bif.comp_ready, bif.enc_first);
                end
            end
        end
        checks = checks + 1;
        if (!seen) begin failures++; $display("FAIL stall_resume_timeout: got none required Cb issue"); end
        wait_done(100, at);
        checks = checks + 1;
        if (exp_q.size() != 0 || n_cw != 12) begin
            failures++;
            $display("FAIL stall_count: got %0d codewords required 12", n_cw);
        end
    endtask

    task automatic test_ignored_starts;
        int at;
        logic busy_seen;
        busy_seen = 1'b0;
        @(posedge clk); #1;
        bif.slice_start = 1'b1; bif.slice_blocks = 6'd0;
        @(posedge clk); #1;
        bif.slice_start = 1'b0;
        repeat (4) begin @(negedge clk); if (bif.slice_busy) busy_seen = 1'b1; end
        checks = checks + 2;
        if (busy_seen) begin failures++; $display("FAIL zero_start_busy: got 1 required 0"); end
        if ({bif.bits_y, bif.bits_cb, bif.bits_cr} !== {16'(exp_bits[0]), 16'(exp_bits[1]), 16'(exp_bits[2])}) begin
            failures++;
            $display("FAIL bits_hold: got %0d/%0d/%0d required %0d/%0d/%0d", bif.bits_y, bif.bits_cb,
                     bif.bits_cr, exp_bits[0], exp_bits[1], exp_bits[2]);
        end
        len_fixed = 0;
        bif.comp_valid = 3'b111;
        bif.cw_ready = 1'b1;
        start_slice(3);
        @(posedge clk); #1;
        bif.slice_start = 1'b1; bif.slice_blocks = 6'd5;
        @(posedge clk); #1;
        bif.slice_start = 1'b0;
        wait_done(100, at);
        checks = checks + 2;
        if (at != 16 || n_cw != 9 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL mid_start: got done at %0d with %0d codewords required 16 and 9", at, n_cw);
        end
        if ({bif.bits_y, bif.bits_cb, bif.bits_cr} !== {16'(exp_bits[0]), 16'(exp_bits[1]), 16'(exp_bits[2])}) begin
            failures++;
            $display("FAIL mid_start_bits: got %0d/%0d/%0d required %0d/%0d/%0d", bif.bits_y, bif.bits_cb,
                     bif.bits_cr, exp_bits[0], exp_bits[1], exp_bits[2]);
        end
    endtask

    task automatic test_reset_mid;
        int n, late, at;
        logic [107:0] outs;
        n = 0; late = 0;
        len_fixed = 0;
        bif.cw_ready = 1'b0;
        bif.comp_valid = 3'b111;
        start_slice(8);
        for (int i = 0; i < 20 && n < 5; i++) begin
            @(negedge clk);
            if (bif.enc_valid) n++;
        end
        @(posedge clk); #1;
        bif.comp_valid = 3'b000;
        @(posedge clk); #1;
        checks = checks + 1;
        if (bif.cw_valid !== 1'b1 || n != 5) begin
            failures++;
            $display("FAIL pre_reset: got cw_valid=%b issues=%0d required 1 and 5", bif.cw_valid, n);
        end
        reset = 1'b1;
        #1;
        outs = {bif.slice_busy, bif.comp_ready, bif.enc_valid, bif.enc_first, bif.enc_coeff,
                bif.cw_valid, bif.cw_code, bif.cw_len, bif.cw_comp, bif.cw_last,
                bif.slice_done, bif.bits_y, bif.bits_cb, bif.bits_cr};
        checks = checks + 1;
        if (outs !== '0) begin failures++; $display("FAIL mid_reset_outputs: got %h required 0", outs); end
        exp_q.delete();
        exp_bits = '{0, 0, 0};
        @(posedge clk); #1;
        reset = 1'b0;
        bif.cw_ready = 1'b1;
        repeat (10) begin @(negedge clk); if (bif.cw_valid) late++; end
        checks = checks + 2;
        if (late != 0) begin failures++; $display("FAIL late_encoder_data: got %0d codewords required 0", late); end
        if ({bif.bits_y, bif.bits_cb, bif.bits_cr} !== 48'd0) begin
            failures++;
            $display("FAIL late_bits: got %0d/%0d/%0d required 0/0/0", bif.bits_y, bif.bits_cb, bif.bits_cr);
        end
        bif.comp_valid = 3'b111;
        start_slice(2);
        wait_done(100, at);
        checks = checks + 1;
        if (at != 13 || n_cw != 6 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL after_reset_slice: got done at %0d with %0d codewords required 13 and 6", at, n_cw);
        end
    endtask

    task automatic test_saturation;
        int at;
        bif.comp_valid = 3'b111;
        bif.cw_ready = 1'b1;
        len_fixed = 24;
        start_slice(63);
        wait_done(400, at);
        checks = checks + 2;
        if (at != 196) begin failures++; $display("FAIL peak_throughput: got done at %0d required 196", at); end
        if ({bif.bits_y, bif.bits_cb, bif.bits_cr} !== {16'd1512, 16'd1512, 16'd1512}) begin
            failures++;
            $display("FAIL bits_1512: got %0d/%0d/%0d required 1512", bif.bits_y, bif.bits_cb, bif.bits_cr);
        end
        len_fixed = 31;
        start_slice(63);
        wait_done(400, at);
        checks = checks + 1;
        if ({bif.bits_y, bif.bits_cb, bif.bits_cr} !== {16'(exp_bits[0]), 16'(exp_bits[1]), 16'(exp_bits[2])}) begin
            failures++;
            $display("FAIL bits_long: got %0d/%0d/%0d required %0d/%0d/%0d", bif.bits_y, bif.bits_cb,
                     bif.bits_cr, exp_bits[0], exp_bits[1], exp_bits[2]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.slice_start  = 1'b0;
        bif.slice_blocks = 6'd0;
        bif.comp_valid   = 3'b000;
        bif.cw_ready     = 1'b0;
        bif.y_coeff      = '0;
        bif.cb_coeff     = '0;
        bif.cr_coeff     = '0;
        bif.enc_code     = '0;
        bif.enc_len      = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_comp_stall();
        test_ignored_starts();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
